// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and size defaults.
package fetch_pkg;

  localparam int unsigned MEM_WORDS_DEF   = 8;
  localparam int unsigned QUEUE_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// Small shift-style FIFO of {pc, instr} pairs; entry 0 is always the head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_instr,
  output logic                  head_valid,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic [CNT_W-1:0]      count
);

  logic [ADDR_WIDTH-1:0] pc_q    [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d    [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] instr_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] instr_d [QUEUE_DEPTH];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      level;

  // Next-state: flush wins; otherwise pop shifts entries down, push lands at the first free slot.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    level   = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop && (count_q != '0)) begin
        for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
          pc_d[i]    = pc_q[i+1];
          instr_d[i] = instr_q[i+1];
        end
        level = count_q - CNT_W'(1);
      end
      if (push && (level < CNT_W'(QUEUE_DEPTH))) begin
        for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
          if (level == CNT_W'(i)) begin
            pc_d[i]    = push_pc;
            instr_d[i] = push_instr;
          end
        end
        level = level + CNT_W'(1);
      end
      count_d = level;
    end
  end

  // Storage and occupancy registers; reset clears payload so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_pc    = pc_q[0];
  assign head_instr = instr_q[0];
  assign count      = count_q;

endmodule : fetch_queue

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a word-indexed program counter through an
// external combinational instruction memory and buffers fetched words for decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = MEM_WORDS_DEF,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  busy,
  output logic                  halted
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;

  logic                  q_flush;
  logic                  q_push;
  logic                  q_pop;
  logic                  q_valid;
  logic [CNT_W-1:0]      q_count;
  logic                  transfer;
  logic                  pc_in_range;
  logic                  target_in_range;

  assign transfer        = q_valid && out_ready;
  assign pc_in_range     = (pc_q < ADDR_WIDTH'(MEM_WORDS));
  assign target_in_range = (redirect_pc < ADDR_WIDTH'(MEM_WORDS));

  // Next-state and queue control; a redirect preempts any fetch or handshake that cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_flush = 1'b0;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN, ST_HALT: begin
        if (redirect_valid) begin
          q_flush = 1'b1;
          if (target_in_range) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALT;
          end
        end else if (state_q == ST_RUN) begin
          q_pop = transfer;
          if (pc_in_range) begin
            if ((q_count < CNT_W'(QUEUE_DEPTH)) || transfer) begin
              q_push = 1'b1;
              pc_d   = pc_q + ADDR_WIDTH'(1);
            end
          end else if (q_count == '0) begin
            state_d = ST_HALT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d   = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  // State, program counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  fetch_queue #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (q_flush),
    .push       (q_push),
    .pop        (q_pop),
    .push_pc    (pc_q),
    .push_instr (imem_instr),
    .head_valid (q_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (q_count)
  );

  assign imem_addr = pc_q;
  assign out_valid = q_valid;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule : fetch_controller
